credit_update_arbiter: RTL and testbench



---
 rtl/credit_update_arbiter.sv | 153 +++++++++++++++
 tb/tb_credit_update_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_update_arbiter.sv
// Round-robin arbiter that funnels per-port credit updates onto one return stream.
// Optional statistics counters are enabled with CREDIT_UPDATE_ARBITER_STATS_EN.
module credit_update_arbiter #(
   parameter int PACKET_BITS  = 97,
   parameter int NUM_IN_PORTS = 7,
   parameter int CNT_BITS     = 16
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_IN_PORTS-1:0]               freespace_update,
   input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]   packet_from_input_ports,
   output logic [PACKET_BITS-1:0]                stream_out,
   output logic                                  stream_out_vld,
   input  logic                                  stream_out_ack,
   output logic [NUM_IN_PORTS-1:0]               pending,
   output logic [$clog2(NUM_IN_PORTS)-1:0]       grant_port
`ifdef CREDIT_UPDATE_ARBITER_STATS_EN
   ,
   output logic [CNT_BITS-1:0]                   coalesce_cnt,
   output logic [CNT_BITS-1:0]                   sent_cnt
`endif
);

   localparam int IDX_W = $clog2(NUM_IN_PORTS);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t                 state;
   logic [PACKET_BITS-1:0] pkt_reg [NUM_IN_PORTS];
   logic [IDX_W-1:0]       last_grant;

   logic [IDX_W-1:0]       win;
   logic [IDX_W-1:0]       rr;
   logic                   found;
   logic                   any_pend;
   logic                   xfer;
   logic                   take;

   if (NUM_IN_PORTS < 2) begin : g_bad_ports
      $error("NUM_IN_PORTS must be at least 2");
   end

   if (CNT_BITS < 4) begin : g_bad_cnt
      $error("CNT_BITS must be at least 4");
   end

   // Search starts one past the previous winner so every port gets a turn.
   always_comb begin
      win   = last_grant;
      rr    = last_grant;
      found = 1'b0;
      for (int k = 1; k <= NUM_IN_PORTS; k++) begin
         rr = IDX_W'((int'(last_grant) + k) % NUM_IN_PORTS);
         if (!found && pending[rr]) begin
            win   = rr;
            found = 1'b1;
         end
      end
   end

   assign any_pend = |pending;
   assign xfer     = stream_out_vld && stream_out_ack;
   assign take     = any_pend && ((state == IDLE) || xfer);

   // A pulse on the port being granted wins over the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
         for (int i = 0; i < NUM_IN_PORTS; i++) begin
            pkt_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_IN_PORTS; i++) begin
            if (freespace_update[i]) begin
               pending[i] <= 1'b1;
               pkt_reg[i] <= packet_from_input_ports[PACKET_BITS*i +: PACKET_BITS];
            end else if (take && (win == IDX_W'(i))) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         stream_out     <= '0;
         stream_out_vld <= 1'b0;
         grant_port     <= '0;
         last_grant     <= IDX_W'(NUM_IN_PORTS - 1);
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  stream_out     <= pkt_reg[win];
                  grant_port     <= win;
                  last_grant     <= win;
                  stream_out_vld <= 1'b1;
                  state          <= SEND;
               end
            end
            SEND: begin
               if (take) begin
                  stream_out     <= pkt_reg[win];
                  grant_port     <= win;
                  last_grant     <= win;
                  stream_out_vld <= 1'b1;
               end else if (xfer) begin
                  stream_out_vld <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: begin
               stream_out_vld <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end

`ifdef CREDIT_UPDATE_ARBITER_STATS_EN
   logic [CNT_BITS:0] coal_hits;
   logic [CNT_BITS:0] coal_sum;

   always_comb begin
      coal_hits = '0;
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
         coal_hits = coal_hits + (CNT_BITS+1)'(freespace_update[i] & pending[i]);
      end
      coal_sum = {1'b0, coalesce_cnt} + coal_hits;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         coalesce_cnt <= '0;
         sent_cnt     <= '0;
      end else begin
         if (coal_sum[CNT_BITS]) begin
            coalesce_cnt <= '1;
         end else begin
            coalesce_cnt <= coal_sum[CNT_BITS-1:0];
         end
         if (xfer && (sent_cnt != '1)) begin
            sent_cnt <= sent_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_credit_update_arbiter.sv
// Directed bench for credit_update_arbiter: latency, ordering, stall,
// coalescing, grant-cycle collision and asynchronous reset.
module tb_credit_update_arbiter;

   localparam int PB = 97;
   localparam int NP = 7;
   localparam int CB = 16;

   logic             clk;
   logic             reset;
   logic [NP-1:0]    freespace_update;
   logic [PB*NP-1:0] packet_from_input_ports;
   logic [PB-1:0]    stream_out;
   logic             stream_out_vld;
   logic             stream_out_ack;
   logic [NP-1:0]    pending;
   logic [2:0]       grant_port;
`ifdef CREDIT_UPDATE_ARBITER_STATS_EN
   logic [CB-1:0]    coalesce_cnt;
   logic [CB-1:0]    sent_cnt;
`endif

   int n_cmp;
   int n_err;

   logic [2:0]    q_port [$];
   logic [PB-1:0] q_pkt  [$];

   credit_update_arbiter #(
      .PACKET_BITS  (PB),
      .NUM_IN_PORTS (NP),
      .CNT_BITS     (CB)
   ) dut (
      .clk                     (clk),
      .reset                   (reset),
      .freespace_update        (freespace_update),
      .packet_from_input_ports (packet_from_input_ports),
      .stream_out              (stream_out),
      .stream_out_vld          (stream_out_vld),
      .stream_out_ack          (stream_out_ack),
      .pending                 (pending),
      .grant_port              (grant_port)
`ifdef CREDIT_UPDATE_ARBITER_STATS_EN
      ,
      .coalesce_cnt            (coalesce_cnt),
      .sent_cnt                (sent_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset && stream_out_vld && stream_out_ack) begin
         q_port.push_back(grant_port);
         q_pkt.push_back(stream_out);
      end
   end

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      freespace_update = '0;
      tick();
      tick();
      reset = 1'b0;
      q_port.delete();
      q_pkt.delete();
   endtask

   function automatic logic [PB-1:0] mk(input int p, input int salt);
      return {1'b1, 32'(salt), 32'hC0DE_0000 | 32'(p), 32'(p * 17 + 3)};
   endfunction

   task automatic pulse(input int p, input logic [PB-1:0] d);
      freespace_update = '0;
      freespace_update[p] = 1'b1;
      packet_from_input_ports[PB*p +: PB] = d;
      tick();
      freespace_update = '0;
   endtask

   logic [PB-1:0] pa;
   logic [PB-1:0] pb;
   logic [PB-1:0] pc;

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      freespace_update = '0;
      packet_from_input_ports = '0;
      stream_out_ack = 1'b0;
      #2;
      chk("rst_vld_async", 128'(stream_out_vld), 128'(0));
      do_reset();

      chk("rst_pending", 128'(pending), 128'(0));
      chk("rst_vld", 128'(stream_out_vld), 128'(0));
      chk("rst_stream", 128'(stream_out), 128'(0));
      chk("rst_grant", 128'(grant_port), 128'(0));

      // single request, ack tied high
      stream_out_ack = 1'b1;
      pa = 97'h1_0000_0000_0000_00AB;
      pulse(3, pa);
      chk("t1_pend", 128'(pending), 128'(7'h08));
      chk("t1_vld0", 128'(stream_out_vld), 128'(0));
      tick();
      chk("t1_vld1", 128'(stream_out_vld), 128'(1));
      chk("t1_data", 128'(stream_out), 128'(pa));
      chk("t1_grant", 128'(grant_port), 128'(3));
      chk("t1_pend0", 128'(pending), 128'(0));
      tick();
      chk("t1_vld_end", 128'(stream_out_vld), 128'(0));
      chk("t1_nxfer", 128'(q_port.size()), 128'(1));

      // all ports at once, back-to-back in order 0..6
      do_reset();
      stream_out_ack = 1'b1;
      for (int i = 0; i < NP; i++) begin
         packet_from_input_ports[PB*i +: PB] = mk(i, 32'h2000 + i);
      end
      freespace_update = 7'h7F;
      tick();
      freespace_update = '0;
      chk("t2_pend", 128'(pending), 128'(7'h7F));
      for (int i = 0; i < NP; i++) begin
         tick();
         chk($sformatf("t2_vld%0d", i), 128'(stream_out_vld), 128'(1));
         chk($sformatf("t2_grant%0d", i), 128'(grant_port), 128'(i));
         chk($sformatf("t2_data%0d", i), 128'(stream_out), 128'(mk(i, 32'h2000 + i)));
      end
      tick();
      chk("t2_vld_end", 128'(stream_out_vld), 128'(0));
      chk("t2_nxfer", 128'(q_port.size()), 128'(7));

      // backpressure on port 0
      do_reset();
      stream_out_ack = 1'b0;
      pa = mk(0, 32'h3333);
      pulse(0, pa);
      tick();
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("t3_vld%0d", j), 128'(stream_out_vld), 128'(1));
         chk($sformatf("t3_data%0d", j), 128'(stream_out), 128'(pa));
         chk($sformatf("t3_grant%0d", j), 128'(grant_port), 128'(0));
         tick();
      end
      chk("t3_nostall_xfer", 128'(q_port.size()), 128'(0));
      stream_out_ack = 1'b1;
      tick();
      chk("t3_vld_end", 128'(stream_out_vld), 128'(0));
      tick();
      chk("t3_nxfer", 128'(q_port.size()), 128'(1));

      // coalesce on port 2 behind a stalled port-5 transfer
      do_reset();
      stream_out_ack = 1'b0;
      pc = mk(5, 32'h5555);
      pa = mk(2, 32'hAAAA);
      pb = mk(2, 32'hBBBB);
      pulse(5, pc);
      tick();
      chk("t4_grant5", 128'(grant_port), 128'(5));
      pulse(2, pa);
      pulse(2, pb);
      chk("t4_pend", 128'(pending), 128'(7'h04));
      stream_out_ack = 1'b1;
      tick();
      chk("t4_vld", 128'(stream_out_vld), 128'(1));
      chk("t4_grant2", 128'(grant_port), 128'(2));
      chk("t4_dataB", 128'(stream_out), 128'(pb));
      tick();
      chk("t4_vld_end", 128'(stream_out_vld), 128'(0));
      chk("t4_nxfer", 128'(q_port.size()), 128'(2));
      if (q_port.size() == 2) begin
         chk("t4_q0port", 128'(q_port[0]), 128'(5));
         chk("t4_q1port", 128'(q_port[1]), 128'(2));
         chk("t4_q1pkt", 128'(q_pkt[1]), 128'(pb));
      end
`ifdef CREDIT_UPDATE_ARBITER_STATS_EN
      chk("t4_coal_cnt", 128'(coalesce_cnt), 128'(1));
      chk("t4_sent_cnt", 128'(sent_cnt), 128'(2));
`endif

      // pulse on port 4 in its own grant cycle
      do_reset();
      stream_out_ack = 1'b1;
      pa = mk(4, 32'h4001);
      pb = mk(4, 32'h4002);
      pulse(4, pa);
      pulse(4, pb);
      chk("t5_vld", 128'(stream_out_vld), 128'(1));
      chk("t5_grant", 128'(grant_port), 128'(4));
      chk("t5_data1", 128'(stream_out), 128'(pa));
      chk("t5_pend", 128'(pending), 128'(7'h10));
      tick();
      chk("t5_vld2", 128'(stream_out_vld), 128'(1));
      chk("t5_grant2", 128'(grant_port), 128'(4));
      chk("t5_data2", 128'(stream_out), 128'(pb));
      chk("t5_pend0", 128'(pending), 128'(0));
      tick();
      chk("t5_vld_end", 128'(stream_out_vld), 128'(0));

      // async reset in the middle of a stalled SEND
      stream_out_ack = 1'b0;
      packet_from_input_ports[PB*1 +: PB] = mk(1, 32'h6001);
      packet_from_input_ports[PB*6 +: PB] = mk(6, 32'h6006);
      freespace_update = 7'h42;
      tick();
      freespace_update = '0;
      tick();
      chk("t6_vld", 128'(stream_out_vld), 128'(1));
      chk("t6_grant", 128'(grant_port), 128'(6));
      chk("t6_pend", 128'(pending), 128'(7'h02));
      #2;
      reset = 1'b1;
      #1;
      chk("t6_vld_async", 128'(stream_out_vld), 128'(0));
      chk("t6_pend_async", 128'(pending), 128'(0));
      #2;
      reset = 1'b0;
      q_port.delete();
      q_pkt.delete();
      stream_out_ack = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick();
      end
      chk("t6_idle_vld", 128'(stream_out_vld), 128'(0));
      chk("t6_no_xfer", 128'(q_port.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
